pconv_c6_ctrl: RTL and testbench
================================

// Module: pconv_c6_ctrl
// PURPOSE
//  Sequencer for the 6-in/OUTPUT_CHANNEL-out pointwise conv array. On start, it loads per-layer
//  weight/bias/shift, then streams INPUT_SIZE*INPUT_SIZE pixel words from the ifm buffer into the
//  array. It collects the array outputs into the ofm buffer and pulses done after the last write.
//  Sits between the layer scheduler, the feature-map RAMs and the pconv array.
// PARAMETERS
//  N              16  data bit width per channel
//  INPUT_SIZE      6  feature-map side; PIX = INPUT_SIZE*INPUT_SIZE pixels per run
//  OUTPUT_CHANNEL 32  array output channels
//  ADDR_W          6  pixel address width, >= $clog2(PIX)
//  MAX_INFLIGHT    4  max pixels issued but not yet written back (1..15)
// PORTS
//  clk            in   1                 clock, rising edge
//  rst            in   1                 async reset, active high
//  start          in   1                 1-cycle run request; ignored unless IDLE
//  abort          in   1                 sync abort; returns to IDLE next cycle
//  busy           out  1                 high in every state except IDLE
//  done           out  1                 1-cycle pulse in DONE
//  err            out  1                 sticky: unexpected array output; cleared by start
//  cfg_load       out  1                 1-cycle strobe; param regs latch weight/bias/shift
//  ifm_rd_en      out  1                 ifm RAM read enable
//  ifm_rd_addr    out  ADDR_W            ifm read address
//  ifm_rd_data    in   6*N               ifm read data, valid 1 cycle after ifm_rd_en
//  conv_ce        out  1                 array enable; low clears array state
//  conv_input_vld out  1                 array input valid
//  conv_din       out  6*N               array input = ifm_rd_data (combinational)
//  conv_dout      in   OUTPUT_CHANNEL*N  array result
//  conv_dout_vld  in   1                 array result valid; cannot be stalled
//  ofm_wr_en      out  1                 ofm RAM write enable
//  ofm_wr_addr    out  ADDR_W            ofm write address
//  ofm_wr_data    out  OUTPUT_CHANNEL*N  = conv_dout (combinational)
// BEHAVIOUR
//  Reset values: state=IDLE; busy, done, cfg_load, ifm_rd_en, conv_ce, conv_input_vld and
//   ofm_wr_en = 0; err=0; all counters and addresses = 0.
//  FSM states: IDLE -> CFG -> RUN -> DRAIN -> DONE -> IDLE.
//  - IDLE: start=1 -> CFG; clear rd_cnt, wr_cnt, inflight and err.
//  - CFG: exactly 1 cycle. cfg_load=1 and conv_ce=1, then -> RUN.
//  - RUN: ifm_rd_en=1 when rd_cnt<PIX && inflight<MAX_INFLIGHT.
//     ifm_rd_addr=rd_cnt; rd_cnt increments on each read.
//     Go to DRAIN in the cycle after the read with rd_cnt==PIX-1 is issued.
//  - DRAIN: no reads. Go to DONE when the write with wr_cnt==PIX-1 occurs.
//  - DONE: done=1, conv_ce=0 for 1 cycle, then -> IDLE.
//  conv_ce=1 in CFG, RUN and DRAIN; conv_ce=0 otherwise.
//  conv_input_vld is ifm_rd_en registered (1-cycle latency, aligned with ifm_rd_data).
//  Write-back:
//  - In RUN or DRAIN, conv_dout_vld=1 && wr_cnt<PIX -> ofm_wr_en=1 (comb), ofm_wr_addr=wr_cnt.
//    wr_cnt increments on each write.
//  - conv_dout_vld=1 in IDLE, CFG or DONE, or when wr_cnt==PIX -> no write, err<=1.
//  inflight counter (4 bit): +1 on a read, -1 on a write, unchanged on a same-cycle read+write.
//   It never wraps; saturate and set err on underflow.
//  Throughput: at most 1 pixel/cycle; issue stalls when inflight==MAX_INFLIGHT.
//  abort: has priority over all transitions. Next state IDLE; conv_ce=0 and ifm_rd_en=0 at once.
//   Counters clear. No done pulse. Pending array results are dropped and do not set err.
//  start while busy is ignored. start and abort in the same IDLE cycle -> stay IDLE.
//  Async rst mid-run: immediate return to reset values. RAM contents are untouched.
// TESTING
//  1. Reset, start, fixed array latency 3, MAX_INFLIGHT=4: 36 reads at addr 0..35 and 36 writes
//     at 0..35 -> done 1 cycle after the 36th write; err=0.
//  2. Array latency 8, MAX_INFLIGHT=4 -> ifm_rd_en never issues a 5th outstanding read;
//     inflight peak = 4; all 36 writes land in order.
//  3. abort at rd_cnt=10 -> busy=0 and conv_ce=0 next cycle, no done.
//     A following start yields a full clean run from addr 0.
//  4. Inject a spurious conv_dout_vld while IDLE -> no ofm_wr_en, err=1.
//     The next start clears err.
//  5. start pulse during RUN and DRAIN -> no effect. Assert rst at wr_cnt=20 -> all outputs at
//     reset values immediately.
//  6. Same-cycle read and write at steady state (latency 1) -> inflight constant at 1,
//     one pixel per cycle, done at cycle 1(CFG)+36+1.

Source files
------------

// File: rtl/pconv_c6_ctrl.sv
// Sequencer for the 6-in pointwise conv array: loads layer parameters, streams one feature map
// from the ifm RAM through the array and writes the results back to the ofm RAM in pixel order.
module pconv_c6_ctrl #(
  parameter int N              = 16,
  parameter int INPUT_SIZE     = 6,
  parameter int OUTPUT_CHANNEL = 32,
  parameter int ADDR_W         = 6,
  parameter int MAX_INFLIGHT   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic                        cfg_load,
  output logic                        ifm_rd_en,
  output logic [ADDR_W-1:0]           ifm_rd_addr,
  input  logic [6*N-1:0]              ifm_rd_data,
  output logic                        conv_ce,
  output logic                        conv_input_vld,
  output logic [6*N-1:0]              conv_din,
  input  logic [OUTPUT_CHANNEL*N-1:0] conv_dout,
  input  logic                        conv_dout_vld,
  output logic                        ofm_wr_en,
  output logic [ADDR_W-1:0]           ofm_wr_addr,
  output logic [OUTPUT_CHANNEL*N-1:0] ofm_wr_data
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int PIX   = INPUT_SIZE * INPUT_SIZE;

  localparam logic [CNT_W-1:0] PIX_C    = CNT_W'(PIX);
  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIX - 1);
  localparam logic [3:0]       MAX_INF  = 4'(MAX_INFLIGHT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] rd_cnt_q;
  logic [CNT_W-1:0] wr_cnt_q;
  logic [3:0]       infl_q;
  logic [3:0]       infl_d;
  logic             infl_unf;
  logic             err_q;
  logic             in_vld_q;

  logic             active;
  logic             rd_fire;
  logic             wr_fire;
  logic             spurious;

  // Abort masks every strobe in the same cycle so nothing issued late reaches the RAMs.
  assign active   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign rd_fire  = (state_q == S_RUN) && (rd_cnt_q < PIX_C) && (infl_q < MAX_INF) && !abort;
  assign wr_fire  = conv_dout_vld && active && (wr_cnt_q < PIX_C) && !abort;
  assign spurious = conv_dout_vld && !abort && !wr_fire;

  always_comb begin
    infl_d   = infl_q;
    infl_unf = 1'b0;
    case ({rd_fire, wr_fire})
      2'b10:   infl_d = infl_q + 4'd1;
      2'b01: begin
        if (infl_q == 4'd0) infl_unf = 1'b1;
        else                infl_d   = infl_q - 4'd1;
      end
      default: infl_d = infl_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      infl_q   <= '0;
      err_q    <= 1'b0;
      in_vld_q <= 1'b0;
    end else begin
      in_vld_q <= rd_fire;
      if (abort) begin
        state_q  <= S_IDLE;
        rd_cnt_q <= '0;
        wr_cnt_q <= '0;
        infl_q   <= '0;
      end else begin
        if (rd_fire) rd_cnt_q <= rd_cnt_q + 1'b1;
        if (wr_fire) wr_cnt_q <= wr_cnt_q + 1'b1;
        infl_q <= infl_d;
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q  <= S_CFG;
              rd_cnt_q <= '0;
              wr_cnt_q <= '0;
              infl_q   <= '0;
              err_q    <= 1'b0;
            end
          end
          S_CFG:   state_q <= S_RUN;
          S_RUN: begin
            if (rd_fire && (rd_cnt_q == PIX_LAST)) state_q <= S_DRAIN;
          end
          S_DRAIN: begin
            if (wr_fire && (wr_cnt_q == PIX_LAST)) state_q <= S_DONE;
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
      // A result nobody asked for is flagged even on the cycle a new run is launched.
      if (spurious || infl_unf) err_q <= 1'b1;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign cfg_load       = (state_q == S_CFG);
  assign err            = err_q;
  assign conv_ce        = ((state_q == S_CFG) || active) && !abort;
  assign ifm_rd_en      = rd_fire;
  assign ifm_rd_addr    = rd_cnt_q[ADDR_W-1:0];
  assign conv_input_vld = in_vld_q;
  assign conv_din       = ifm_rd_data;
  assign ofm_wr_en      = wr_fire;
  assign ofm_wr_addr    = wr_cnt_q[ADDR_W-1:0];
  assign ofm_wr_data    = conv_dout;

endmodule

// File: tb/tb_pconv_c6_ctrl.sv
// Directed bench for pconv_c6_ctrl with an ifm RAM model and a fixed-latency array model.
module tb_pconv_c6_ctrl;

  localparam int N      = 16;
  localparam int OC     = 32;
  localparam int ADDR_W = 6;
  localparam int MAXI   = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic              err;
  logic              cfg_load;
  logic              ifm_rd_en;
  logic [ADDR_W-1:0] ifm_rd_addr;
  logic [6*N-1:0]    ifm_rd_data;
  logic              conv_ce;
  logic              conv_input_vld;
  logic [6*N-1:0]    conv_din;
  logic [OC*N-1:0]   conv_dout;
  logic              conv_dout_vld;
  logic              ofm_wr_en;
  logic [ADDR_W-1:0] ofm_wr_addr;
  logic [OC*N-1:0]   ofm_wr_data;

  pconv_c6_ctrl #(
    .N(N), .INPUT_SIZE(6), .OUTPUT_CHANNEL(OC), .ADDR_W(ADDR_W), .MAX_INFLIGHT(MAXI)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done), .err(err),
    .cfg_load(cfg_load), .ifm_rd_en(ifm_rd_en), .ifm_rd_addr(ifm_rd_addr),
    .ifm_rd_data(ifm_rd_data), .conv_ce(conv_ce), .conv_input_vld(conv_input_vld),
    .conv_din(conv_din), .conv_dout(conv_dout), .conv_dout_vld(conv_dout_vld),
    .ofm_wr_en(ofm_wr_en), .ofm_wr_addr(ofm_wr_addr), .ofm_wr_data(ofm_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int lat = 3;
  logic inj_vld = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // ifm RAM: channel k of pixel a holds 0x1000 + k*0x100 + a
  always @(posedge clk) begin
    if (ifm_rd_en)
      for (int k = 0; k < 6; k++)
        ifm_rd_data[k*N +: N] <= 16'h1000 + 16'(k * 256) + 16'(ifm_rd_addr);
  end

  // Array: result channel j = input channel 0 + j, 'lat' cycles after the read strobe
  logic        vp [0:7];
  logic [15:0] dp [0:7];
  logic        arr_vld;
  logic [15:0] arr_d;

  always @(posedge clk) begin
    if (!conv_ce) begin
      for (int i = 0; i < 8; i++) begin
        vp[i] <= 1'b0;
        dp[i] <= 16'h0;
      end
    end else begin
      vp[0] <= conv_input_vld;
      dp[0] <= conv_din[15:0];
      for (int i = 1; i < 8; i++) begin
        vp[i] <= vp[i-1];
        dp[i] <= dp[i-1];
      end
    end
  end

  always_comb begin
    arr_vld = conv_input_vld;
    arr_d   = conv_din[15:0];
    if (lat > 1) begin
      arr_vld = vp[lat-2];
      arr_d   = dp[lat-2];
    end
    for (int j = 0; j < OC; j++) conv_dout[j*N +: N] = arr_d + 16'(j);
  end

  assign conv_dout_vld = arr_vld | inj_vld;

  // Event recorder
  int n_rd, n_wr, rd_bad, wr_bad, data_bad, n_done, n_cfg, done_cyc, first_wr, last_wr;
  int infl, peak, over;

  always @(negedge clk) begin
    int infl_before;
    infl_before = infl;
    if (ifm_rd_en) begin
      if (ifm_rd_addr != ADDR_W'(n_rd)) rd_bad++;
      if (infl_before >= MAXI) over++;
      n_rd++;
      infl++;
    end
    if (ofm_wr_en) begin
      if (ofm_wr_addr != ADDR_W'(n_wr)) wr_bad++;
      if (ofm_wr_data[15:0] != 16'h1000 + 16'(ofm_wr_addr) ||
          ofm_wr_data[31*N +: N] != 16'h1000 + 16'(ofm_wr_addr) + 16'd31) data_bad++;
      if (n_wr == 0) first_wr = cyc;
      last_wr = cyc;
      n_wr++;
      infl--;
    end
    if (infl > peak) peak = infl;
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (cfg_load) n_cfg++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    n_rd = 0; n_wr = 0; rd_bad = 0; wr_bad = 0; data_bad = 0; n_done = 0; n_cfg = 0;
    done_cyc = 0; first_wr = 0; last_wr = 0; infl = 0; peak = 0; over = 0;
  endtask

  int start_cyc;

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (n_done == 0 && t < 600) begin
      @(posedge clk); #1;
      t++;
    end
    check({tag, "_no_timeout"}, 64'(n_done != 0), 64'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_run(input string tag);
    check({tag, "_rd_cnt"}, 64'(n_rd), 64'd36);
    check({tag, "_rd_order"}, 64'(rd_bad), 64'd0);
    check({tag, "_wr_cnt"}, 64'(n_wr), 64'd36);
    check({tag, "_wr_order"}, 64'(wr_bad), 64'd0);
    check({tag, "_wr_data"}, 64'(data_bad), 64'd0);
    check({tag, "_done_once"}, 64'(n_done), 64'd1);
    check({tag, "_done_after_last_wr"}, 64'(done_cyc), 64'(last_wr + 1));
    check({tag, "_over_issue"}, 64'(over), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    clr_mon();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          64'({busy, done, cfg_load, ifm_rd_en, conv_ce, conv_input_vld, ofm_wr_en, err,
               ifm_rd_addr, ofm_wr_addr}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // start together with abort in IDLE stays idle
    clr_mon();
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("start_abort_cfg", 64'(n_cfg), 64'd0);

    // 1: latency 3
    lat = 3;
    clr_mon();
    do_start();
    check("t1_cfg_load", 64'(cfg_load), 64'd1);
    check("t1_conv_ce_cfg", 64'(conv_ce), 64'd1);
    wait_done("t1");
    check_run("t1");
    check("t1_done_cycle", 64'(done_cyc - start_cyc), 64'd41);
    check("t1_peak", 64'(peak), 64'd3);
    check("t1_conv_ce_idle", 64'(conv_ce), 64'd0);

    // 2: latency 8, issue must stall at MAX_INFLIGHT
    lat = 8;
    clr_mon();
    do_start();
    wait_done("t2");
    check_run("t2");
    check("t2_peak", 64'(peak), 64'd4);

    // 3: abort at rd_cnt=10
    lat = 3;
    clr_mon();
    do_start();
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(ifm_rd_en && ifm_rd_addr == 6'd10) && t < 200);
    check("t3_reach_rd10", 64'(t < 200), 64'd1);
    abort = 1'b1;
    #1;
    check("t3_abort_rd_en", 64'(ifm_rd_en), 64'd0);
    check("t3_abort_ce", 64'(conv_ce), 64'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    check("t3_busy_after", 64'(busy), 64'd0);
    check("t3_ce_after", 64'(conv_ce), 64'd0);
    repeat (20) @(posedge clk);
    #1;
    check("t3_no_done", 64'(n_done), 64'd0);
    check("t3_err", 64'(err), 64'd0);
    clr_mon();
    do_start();
    wait_done("t3b");
    check_run("t3b");

    // 4: spurious result while idle
    @(posedge clk); #1;
    inj_vld = 1'b1;
    @(negedge clk);
    check("t4_no_write", 64'(ofm_wr_en), 64'd0);
    @(posedge clk); #1;
    inj_vld = 1'b0;
    check("t4_err_set", 64'(err), 64'd1);
    clr_mon();
    do_start();
    check("t4_err_cleared", 64'(err), 64'd0);
    wait_done("t4");
    check_run("t4");

    // 5: start pulses during RUN and DRAIN are ignored
    clr_mon();
    do_start();
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (n_rd < 36 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t5");
    check_run("t5");
    check("t5_single_cfg", 64'(n_cfg), 64'd1);

    // 5b: async reset at wr_cnt=20
    clr_mon();
    do_start();
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(ofm_wr_en && ofm_wr_addr == 6'd20) && t < 200);
    check("t5_reach_wr20", 64'(t < 200), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_outputs",
          64'({busy, done, cfg_load, ifm_rd_en, conv_ce, conv_input_vld, ofm_wr_en, err,
               ifm_rd_addr, ofm_wr_addr}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("t5_idle_after_rst", 64'(busy), 64'd0);

    // 6: latency 1, one pixel per cycle with inflight at 1
    lat = 1;
    clr_mon();
    do_start();
    wait_done("t6");
    check_run("t6");
    check("t6_peak", 64'(peak), 64'd1);
    check("t6_wr_span", 64'(last_wr - first_wr), 64'd35);
    check("t6_done_cycle", 64'(done_cyc - start_cyc), 64'd39);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
